// File: rtl/ldl_p1ram_ctrl_v1.sv
// Single-port RAM request/response controller with a 2-entry ordered read-response FIFO.
// Define LDL_P1RAM_CTRL_INIT_EN to zero-fill the RAM after reset before accepting requests.
module ldl_p1ram_ctrl_v1 #(
   parameter int DWIDTH = 8,
   parameter int DEEPTH = 10,
   parameter int AWIDTH = $clog2(DEEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              ram_re,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic              init_done,
   output logic              addr_err
);

   localparam logic [AWIDTH:0]   DEPTH_EXT = (AWIDTH + 1)'(DEEPTH);
   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEEPTH - 1);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t state, state_nxt;

   logic              addr_oob;
   logic              can_accept;
   logic              accept;
   logic              inflight;
   logic              inflight_oob;
   logic [DWIDTH-1:0] cap_data;
   logic [DWIDTH-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic [1:0]        occ;
   logic              fifo_nonempty;
   logic              pop;
   logic              fifo_pop;
   logic              push;

   // Occupancy counts buffered responses plus the read still coming back from the RAM.
   assign occ           = fifo_cnt + {1'b0, inflight};
   assign can_accept    = (state == S_RUN) && (occ < 2'd2);
   assign accept        = req_valid && can_accept;
   assign addr_oob      = ({1'b0, req_addr} >= DEPTH_EXT);
   assign fifo_nonempty = (fifo_cnt != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef LDL_P1RAM_CTRL_INIT_EN
   logic [AWIDTH-1:0] init_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_addr <= '0;
      end else if ((state == S_INIT) && (init_addr != LAST_ADDR)) begin
         init_addr <= init_addr + AWIDTH'(1);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      init_done = 1'b0;
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = req_addr;
      ram_din   = req_wdata;
      case (state)
         S_INIT: begin
`ifdef LDL_P1RAM_CTRL_INIT_EN
            // Gate with rst so the fill write is not driven while reset is held.
            ram_we   = !rst;
            ram_addr = init_addr;
            ram_din  = '0;
            if (init_addr == LAST_ADDR) begin
               state_nxt = S_RUN;
            end
`else
            state_nxt = S_RUN;
`endif
         end
         S_RUN: begin
            init_done = 1'b1;
            req_ready = can_accept;
            ram_re    = accept && !req_we && !addr_oob;
            ram_we    = accept &&  req_we && !addr_oob;
         end
         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

   // Read data is presented straight from the RAM when the FIFO is empty, so a
   // consumer that is ready never lets it occupy a FIFO slot and reads stream 1/cycle.
   assign cap_data  = inflight_oob ? '0 : ram_dout;
   assign rsp_valid = fifo_nonempty || inflight;
   assign rsp_rdata = fifo_nonempty ? fifo_mem[rd_ptr] : (inflight ? cap_data : '0);
   assign pop       = rsp_valid && rsp_ready;
   assign fifo_pop  = pop && fifo_nonempty;
   assign push      = inflight && !(!fifo_nonempty && rsp_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight     <= 1'b0;
         inflight_oob <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_cnt     <= 2'd0;
         addr_err     <= 1'b0;
      end else begin
         inflight     <= accept && !req_we;
         inflight_oob <= addr_oob;
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (fifo_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + 2'(push) - 2'(fifo_pop);
         if (accept && addr_oob) begin
            addr_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= cap_data;
      end
   end

endmodule

// File: tb/tb_ldl_p1ram_ctrl_v1.sv
// Directed bench for ldl_p1ram_ctrl_v1 with a behavioural single-port RAM (registered read).
module tb_ldl_p1ram_ctrl_v1;

   localparam int DW = 8;
   localparam int DP = 10;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ram_re;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          init_done;
   logic          addr_err;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] exp_after_reset;

   int checks = 0;
   int errors = 0;

   ldl_p1ram_ctrl_v1 #(
      .DWIDTH (DW),
      .DEEPTH (DP),
      .AWIDTH (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_re    (ram_re),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .init_done (init_done),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h5A;
      ram_dout = '0;
   end

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      #1;
   endtask

   task automatic check_init();
`ifdef LDL_P1RAM_CTRL_INIT_EN
      for (int i = 0; i < DP; i++) begin
         chk("init_we", ram_we, 1);
         chk("init_addr", ram_addr, i);
         chk("init_din", ram_din, 0);
         chk("init_rdy", req_ready, 0);
         chk("init_done_lo", init_done, 0);
         step();
      end
      chk("init_we_end", ram_we, 0);
      chk("init_done", init_done, 1);
`else
      chk("init_we0", ram_we, 0);
      chk("init_done_lo", init_done, 0);
      chk("init_rdy", req_ready, 0);
      step();
      chk("init_done", init_done, 1);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef LDL_P1RAM_CTRL_INIT_EN
      exp_after_reset = 8'h00;
`else
      exp_after_reset = 8'h31;
`endif
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      step();
      step();

      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_ram_re", ram_re, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_init_done", init_done, 0);

      rst = 1'b0;
      #1;
      check_init();

`ifdef LDL_P1RAM_CTRL_INIT_EN
      drive(1, 0, 5, 0);
      chk("rd5_re", ram_re, 1);
      step();
      drive(0, 0, 0, 0);
      chk("rd5_valid", rsp_valid, 1);
      chk("rd5_data", rsp_rdata, 0);
      step();
`endif

      // write then read the same address in the next cycle
      drive(1, 1, 3, 8'hA5);
      chk("wr3_ready", req_ready, 1);
      chk("wr3_we", ram_we, 1);
      chk("wr3_re", ram_re, 0);
      chk("wr3_addr", ram_addr, 3);
      chk("wr3_din", ram_din, 8'hA5);
      step();
      drive(1, 0, 3, 0);
      chk("rd3_re", ram_re, 1);
      chk("rd3_we", ram_we, 0);
      chk("rd3_nrsp", rsp_valid, 0);
      step();
      drive(0, 0, 0, 0);
      chk("rd3_valid", rsp_valid, 1);
      chk("rd3_data", rsp_rdata, 8'hA5);
      step();
      chk("rd3_done", rsp_valid, 0);

      // backpressure: two reads fill the pipeline, the third waits
      drive(1, 1, 1, 8'h11); step();
      drive(1, 1, 2, 8'h22); step();
      drive(1, 1, 4, 8'h44); step();
      rsp_ready = 1'b0;
      drive(1, 0, 1, 0);
      chk("bp_a_ready", req_ready, 1);
      step();
      drive(1, 0, 2, 0);
      chk("bp_b_ready", req_ready, 1);
      chk("bp_b_valid", rsp_valid, 1);
      chk("bp_b_data", rsp_rdata, 8'h11);
      step();
      drive(1, 0, 4, 0);
      chk("bp_c_ready", req_ready, 0);
      chk("bp_c_re", ram_re, 0);
      chk("bp_c_data", rsp_rdata, 8'h11);
      step();
      chk("bp_d_ready", req_ready, 0);
      chk("bp_d_valid", rsp_valid, 1);
      chk("bp_d_data", rsp_rdata, 8'h11);
      step();
      rsp_ready = 1'b1;
      #1;
      chk("bp_e_ready", req_ready, 0);
      chk("bp_e_data", rsp_rdata, 8'h11);
      step();
      chk("bp_f_ready", req_ready, 1);
      chk("bp_f_data", rsp_rdata, 8'h22);
      chk("bp_f_re", ram_re, 1);
      chk("bp_f_addr", ram_addr, 4);
      step();
      drive(0, 0, 0, 0);
      chk("bp_g_valid", rsp_valid, 1);
      chk("bp_g_data", rsp_rdata, 8'h44);
      step();
      chk("bp_h_valid", rsp_valid, 0);

      // streaming reads with the consumer always ready
      for (int k = 0; k < 8; k++) begin
         drive(1, 1, AW'(k), DW'(8'h30 + k));
         step();
      end
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, AW'(k), 0);
         chk("bb_ready", req_ready, 1);
         if (k > 0) begin
            chk("bb_valid", rsp_valid, 1);
            chk("bb_data", rsp_rdata, 32'h30 + k - 1);
         end
         step();
      end
      drive(0, 0, 0, 0);
      chk("bb_last_valid", rsp_valid, 1);
      chk("bb_last_data", rsp_rdata, 8'h37);
      step();
      chk("bb_drain", rsp_valid, 0);

      // out-of-range address
      drive(1, 1, 12, 8'hFF);
      chk("oob_wr_ready", req_ready, 1);
      chk("oob_wr_we", ram_we, 0);
      chk("oob_wr_re", ram_re, 0);
      chk("oob_err_lo", addr_err, 0);
      step();
      chk("oob_err_set", addr_err, 1);
      drive(1, 0, 12, 0);
      chk("oob_rd_re", ram_re, 0);
      chk("oob_rd_we", ram_we, 0);
      step();
      drive(0, 0, 0, 0);
      chk("oob_rd_valid", rsp_valid, 1);
      chk("oob_rd_data", rsp_rdata, 0);
      chk("oob_err_keep", addr_err, 1);
      step();
      chk("oob_rd_done", rsp_valid, 0);

      // reset with two responses buffered
      rsp_ready = 1'b0;
      drive(1, 0, 0, 0); step();
      drive(1, 0, 1, 0); step();
      drive(0, 0, 0, 0);
      chk("mr_valid_pre", rsp_valid, 1);
      chk("mr_data_pre", rsp_rdata, 8'h30);
      rst = 1'b1;
      #1;
      chk("mr_rsp_valid", rsp_valid, 0);
      chk("mr_rsp_rdata", rsp_rdata, 0);
      chk("mr_req_ready", req_ready, 0);
      chk("mr_addr_err", addr_err, 0);
      chk("mr_init_done", init_done, 0);
      chk("mr_ram_we", ram_we, 0);
      step();
      rsp_ready = 1'b1;
      rst = 1'b0;
      #1;
      check_init();
      chk("mr_no_stale", rsp_valid, 0);
      drive(1, 0, 1, 0);
      chk("mr_rd_ready", req_ready, 1);
      step();
      drive(0, 0, 0, 0);
      chk("mr_rd_valid", rsp_valid, 1);
      chk("mr_rd_data", rsp_rdata, exp_after_reset);
      step();
      chk("mr_rd_done", rsp_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ldl_p1ram_ctrl_v1.md
LDL_P1RAM_CTRL_V1 -- requirements
Module: LDL_p1ram_ctrl_v1

Interface
REQ-001 Parameter DWIDTH, default 8, data width of the RAM word.
REQ-002 Parameter DEEPTH, default 10, number of RAM words.
REQ-003 Parameter AWIDTH, default $clog2(DEEPTH), address width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when high with req_valid.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AWIDTH  request address.
REQ-010 req_wdata  input  DWIDTH  write data.
REQ-011 rsp_valid  output  1  read response present.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_rdata  output  DWIDTH  read response data.
REQ-014 ram_re, ram_we  output  1 each  single-port RAM read and write enables.
REQ-015 ram_addr  output  AWIDTH; ram_din  output  DWIDTH  RAM address and write data.
REQ-016 ram_dout  input  DWIDTH  RAM registered read data, valid one cycle after ram_re.
REQ-017 init_done  output  1  high when the controller is accepting requests.
REQ-018 addr_err  output  1  sticky out-of-range address flag.

Function
REQ-019 The block SHALL issue at most one RAM operation per cycle; ram_re and ram_we SHALL never be high together.
REQ-020 Request handshake at cycle N SHALL drive ram_re/ram_we, ram_addr and ram_din combinationally in cycle N.
REQ-021 A read SHALL capture ram_dout at N+1 into a 2-entry response FIFO; rsp_valid SHALL rise no earlier than N+1.
REQ-022 occ = FIFO entries + reads in flight (0..2); req_ready SHALL be high only when init_done=1 and occ<2, and SHALL NOT depend combinationally on rsp_ready, req_valid or req_we.
REQ-023 Writes SHALL produce no response; a write and a read in consecutive cycles to one address SHALL return the new data.
REQ-024 With rsp_ready held high, back-to-back reads SHALL sustain one request per cycle.
REQ-025 The response FIFO SHALL pop on rsp_valid&&rsp_ready, push on read capture, allow simultaneous push and pop, and preserve request order.
REQ-026 rsp_valid and rsp_rdata SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-027 A request with req_addr>=DEEPTH SHALL be accepted but assert no RAM enable, and SHALL set addr_err.
REQ-028 A read with req_addr>=DEEPTH SHALL still return one response, with data all-zero, in order.
REQ-029 The FSM SHALL have states INIT and RUN; INIT->RUN after the last init write; RUN is terminal until reset.

Reset
REQ-030 On rst: req_ready=0, rsp_valid=0, rsp_rdata=0, ram_re=0, ram_we=0, addr_err=0, init_done=0, FIFO empty, in-flight read discarded, FSM in INIT.
REQ-031 Reset asserted mid-operation SHALL drop all pending responses; after release, INIT SHALL restart from address 0.

Configuration
REQ-032 With LDL_P1RAM_CTRL_INIT_EN defined, INIT SHALL write zero to addresses 0..DEEPTH-1, one per cycle, starting the first cycle after reset release, with req_ready=0; init_done SHALL rise the cycle after the write to DEEPTH-1.
REQ-033 Without LDL_P1RAM_CTRL_INIT_EN, INIT SHALL last one cycle with no RAM writes, and init_done SHALL rise the first cycle after reset release.

Verification
REQ-034 INIT_EN defined, DEEPTH=10, reset release -> ram_we high 10 cycles on addr 0..9 with din 0, then init_done=1; a read of addr 5 returns 0.
REQ-035 Write addr 3 = 0xA5, next cycle read addr 3 -> rsp_rdata=0xA5 one cycle after the read is accepted.
REQ-036 rsp_ready=0, three reads issued -> two accepted, req_ready low; raise rsp_ready -> responses in order, then third accepted.
REQ-037 rsp_ready=1, 8 back-to-back reads -> 8 consecutive accepts and 8 consecutive responses, no bubbles.
REQ-038 Write addr 12 (DEEPTH=10) -> no ram_we, addr_err=1; read addr 12 -> response 0x00, addr_err stays 1.
REQ-039 rst pulsed with 2 responses buffered -> rsp_valid=0 immediately, no stale response after release, INIT restarts.
